// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: command FSM state encoding, response codes and the default error read data.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RDATA,
        ST_RESP
    } cmd_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [31:0] DEF_ERR_RDATA   = 32'hDEAD_BEEF;

    // States in which the bus is occupied and the timeout counter runs.
    function automatic logic is_bus_state(cmd_state_t s);
        return (s == ST_WRITE) || (s == ST_WRESP) || (s == ST_READ) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite channel bundle with master and slave views.
interface AXI_LITE #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
    );
endinterface

// File: rtl/axi_timeout_cnt.sv
// Per-access timeout counter: cleared when a command is accepted, counts while the bus is occupied,
// and saturates at its limit so expiry stays asserted until the next clear.
module axi_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expire
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI-Lite master: converts a command/response stream into AXI-Lite
// reads and writes, with a per-access timeout that returns an error response.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(DEF_ERR_RDATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    AXI_LITE.master           axi
);

    cmd_state_t        r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_wlast;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_aw_done;
    logic              r_w_done;

    logic w_accept;
    logic w_bus;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_complete;
    logic w_expire;

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && i_req_valid;
    assign w_bus    = is_bus_state(r_state);
    assign w_aw_hs  = r_awvalid && axi.awready;
    assign w_w_hs   = r_wvalid && axi.wready;

    // Handshake that ends the current bus state; it takes priority over an expiring timeout.
    always_comb begin
        w_complete = 1'b0;
        case (r_state)
            ST_WRITE: w_complete = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
            ST_WRESP: w_complete = r_bready && axi.bvalid;
            ST_READ:  w_complete = r_arvalid && axi.arready;
            ST_RDATA: w_complete = r_rready && axi.rvalid;
            default:  w_complete = 1'b0;
        endcase
    end

    axi_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_en    (w_bus),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
        end else if (w_bus && w_expire && !w_complete) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= ERR_RDATA;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        if (i_req_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_wlast   <= 1'b1;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_READ;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_complete) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (w_complete) begin
                        r_bready    <= 1'b0;
                        r_rsp_err   <= (axi.bresp != AXI_RESP_OKAY);
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (w_complete) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (w_complete) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= axi.rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // req_ready is re-armed from IDLE, so there is always one idle cycle between commands.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;

    assign axi.awaddr  = r_addr;
    assign axi.araddr  = r_addr;
    assign axi.wdata   = r_wdata;
    assign axi.awvalid = r_awvalid;
    assign axi.wvalid  = r_wvalid;
    assign axi.wlast   = r_wlast;
    assign axi.bready  = r_bready;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

endmodule
